// File: rtl/pipeline_hazard_controller_if.sv
// Hazard controller bundle: ID operand usage, EX load/branch status and
// data-memory busy towards the controller; PC/pipeline-register enables,
// flushes and state back to the pipeline.
// Optional macro HAZARD_PERF_COUNTERS_EN adds the performance counter outputs.
interface pipeline_hazard_controller_if #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int COUNT_WIDTH    = 16
);
   logic [REG_ADDR_WIDTH-1:0] id_rd_addr1;
   logic                      id_rd_en1;
   logic [REG_ADDR_WIDTH-1:0] id_rd_addr2;
   logic                      id_rd_en2;
   logic                      ex_mem_rd_en;
   logic [REG_ADDR_WIDTH-1:0] ex_wr_addr;
   logic                      ex_branch_taken;
   logic                      dmem_busy;
   logic                      pc_wr_en;
   logic                      if_id_wr_en;
   logic                      if_id_flush;
   logic                      id_ex_wr_en;
   logic                      id_ex_flush;
   logic                      ex_mem_wr_en;
   logic [1:0]                ctrl_state;
`ifdef HAZARD_PERF_COUNTERS_EN
   logic [COUNT_WIDTH-1:0]    stall_cycles_out;
   logic [COUNT_WIDTH-1:0]    flush_cycles_out;
   logic [COUNT_WIDTH-1:0]    mem_wait_cycles_out;
`endif

   // Pipeline side: drives status, receives controls
   modport master (
      output id_rd_addr1, id_rd_en1, id_rd_addr2, id_rd_en2,
      output ex_mem_rd_en, ex_wr_addr, ex_branch_taken, dmem_busy,
      input  pc_wr_en, if_id_wr_en, if_id_flush, id_ex_wr_en,
      input  id_ex_flush, ex_mem_wr_en, ctrl_state
`ifdef HAZARD_PERF_COUNTERS_EN
      , input stall_cycles_out, flush_cycles_out, mem_wait_cycles_out
`endif
   );

   // Controller side
   modport slave (
      input  id_rd_addr1, id_rd_en1, id_rd_addr2, id_rd_en2,
      input  ex_mem_rd_en, ex_wr_addr, ex_branch_taken, dmem_busy,
      output pc_wr_en, if_id_wr_en, if_id_flush, id_ex_wr_en,
      output id_ex_flush, ex_mem_wr_en, ctrl_state
`ifdef HAZARD_PERF_COUNTERS_EN
      , output stall_cycles_out, flush_cycles_out, mem_wait_cycles_out
`endif
   );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the uDLX 5-stage pipeline.
// Handles load-use bubbles, taken-branch flushes and data-memory wait; a
// saved-context register lets a memory wait resume the interrupted sequence.
// Optional macro HAZARD_PERF_COUNTERS_EN adds saturating cycle counters.
module pipeline_hazard_controller #(
   parameter int REG_ADDR_WIDTH  = 5,
   parameter int LU_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES    = 1,
   parameter int COUNT_WIDTH     = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   pipeline_hazard_controller_if.slave bus
);

   if (LU_STALL_CYCLES < 1 || LU_STALL_CYCLES > 7) begin : g_bad_lu
      $error("LU_STALL_CYCLES must be in 1..7");
   end
   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_fl
      $error("FLUSH_CYCLES must be in 1..7");
   end
   if (COUNT_WIDTH < 1) begin : g_bad_cw
      $error("COUNT_WIDTH must be at least 1");
   end

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_LU_STALL = 2'b01,
      ST_FLUSH    = 2'b10,
      ST_MEM_WAIT = 2'b11
   } state_t;

   localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG  = '0;
   localparam logic [2:0]                LU_RELOAD = 3'(LU_STALL_CYCLES - 1);
   localparam logic [2:0]                FL_RELOAD = 3'(FLUSH_CYCLES - 1);

   state_t     state, state_nxt;
   state_t     saved_state, saved_nxt;
   logic [2:0] cnt, cnt_nxt;

   logic load_use;
   logic pc_we, if_id_we, if_id_fl, id_ex_we, id_ex_fl, ex_mem_we;

   assign load_use = bus.ex_mem_rd_en && (bus.ex_wr_addr != ZERO_REG) &&
                     ((bus.id_rd_en1 && (bus.id_rd_addr1 == bus.ex_wr_addr)) ||
                      (bus.id_rd_en2 && (bus.id_rd_addr2 == bus.ex_wr_addr)));

   // State, saved context and sequence counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         saved_state <= ST_RUN;
         cnt         <= '0;
      end else begin
         state       <= state_nxt;
         saved_state <= saved_nxt;
         cnt         <= cnt_nxt;
      end
   end

   // Next-state and control outputs; priority dmem_busy > branch > load-use
   always_comb begin
      state_nxt = state;
      saved_nxt = saved_state;
      cnt_nxt   = cnt;
      pc_we     = 1'b1;
      if_id_we  = 1'b1;
      if_id_fl  = 1'b0;
      id_ex_we  = 1'b1;
      id_ex_fl  = 1'b0;
      ex_mem_we = 1'b1;
      if (state == ST_MEM_WAIT) begin
         // Release cycle keeps RUN-default outputs; the context resumes next
         if (bus.dmem_busy) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
         end else begin
            state_nxt = saved_state;
         end
      end else if (bus.dmem_busy) begin
         pc_we     = 1'b0;
         if_id_we  = 1'b0;
         id_ex_we  = 1'b0;
         ex_mem_we = 1'b0;
         saved_nxt = state;
         state_nxt = ST_MEM_WAIT;
      end else if (bus.ex_branch_taken) begin
         if_id_fl = 1'b1;
         id_ex_fl = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            cnt_nxt   = FL_RELOAD;
            state_nxt = ST_FLUSH;
         end else begin
            state_nxt = ST_RUN;
         end
      end else if (state == ST_FLUSH) begin
         if_id_fl = 1'b1;
         cnt_nxt  = cnt - 3'd1;
         if (cnt == 3'd1) state_nxt = ST_RUN;
      end else if ((state == ST_LU_STALL) || load_use) begin
         pc_we    = 1'b0;
         if_id_we = 1'b0;
         id_ex_fl = 1'b1;
         if (state == ST_LU_STALL) begin
            cnt_nxt = cnt - 3'd1;
            if (cnt == 3'd1) state_nxt = ST_RUN;
         end else if (LU_STALL_CYCLES > 1) begin
            cnt_nxt   = LU_RELOAD;
            state_nxt = ST_LU_STALL;
         end
      end
   end

   assign bus.pc_wr_en     = rst_n & pc_we;
   assign bus.if_id_wr_en  = rst_n & if_id_we;
   assign bus.if_id_flush  = rst_n & if_id_fl;
   assign bus.id_ex_wr_en  = rst_n & id_ex_we;
   assign bus.id_ex_flush  = rst_n & id_ex_fl;
   assign bus.ex_mem_wr_en = rst_n & ex_mem_we;
   assign bus.ctrl_state   = state;

`ifdef HAZARD_PERF_COUNTERS_EN
   logic [COUNT_WIDTH-1:0] stall_cnt, flush_cnt, wait_cnt;
   logic                   stall_cyc;

   // A stall cycle is recognised by its output pattern, so single-cycle RUN
   // stalls count the same as LU_STALL cycles
   assign stall_cyc = rst_n & ~pc_we & ~if_id_we & id_ex_fl;

   // Saturating performance counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
         wait_cnt  <= '0;
      end else begin
         if (stall_cyc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (if_id_fl && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
         if ((state == ST_MEM_WAIT) && (wait_cnt != '1)) wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign bus.stall_cycles_out    = stall_cnt;
   assign bus.flush_cycles_out    = flush_cnt;
   assign bus.mem_wait_cycles_out = wait_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed vector table,
// hand-written multi-cycle sequences and randomized stimulus against a
// remaining-cycles reference model.
module tb_pipeline_hazard_controller;
   localparam int LU = 2;
   localparam int FL = 3;
   localparam int CW = 4;

   // Output patterns {pc, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we}
   localparam logic [5:0] O_RUN   = 6'b110101;
   localparam logic [5:0] O_STALL = 6'b000111;
   localparam logic [5:0] O_BR    = 6'b111111;
   localparam logic [5:0] O_FLUSH = 6'b111101;
   localparam logic [5:0] O_FRZ   = 6'b000000;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   pipeline_hazard_controller_if #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(CW)) bus ();

   pipeline_hazard_controller #(
      .REG_ADDR_WIDTH (5),
      .LU_STALL_CYCLES(LU),
      .FLUSH_CYCLES   (FL),
      .COUNT_WIDTH    (CW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] a1;
      logic       e1;
      logic [4:0] a2;
      logic       e2;
      logic       ld;
      logic [4:0] wa;
      logic       br;
      logic       busy;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[21];

   // Reference model state: cycles remaining in each sequence
   int stall_left, flush_left;
   bit waiting;
   int m_stall_n, m_flush_n, m_wait_n;

   function automatic vec_t mk(input logic [4:0] a1, input logic e1, input logic [4:0] a2,
                               input logic e2, input logic ld, input logic [4:0] wa,
                               input logic br, input logic busy, input logic [5:0] o,
                               input logic [1:0] st);
      vec_t v;
      v.a1 = a1; v.e1 = e1; v.a2 = a2; v.e2 = e2; v.ld = ld; v.wa = wa;
      v.br = br; v.busy = busy; v.exp = {o, st};
      return v;
   endfunction

   function automatic logic [7:0] get_out();
      return {bus.pc_wr_en, bus.if_id_wr_en, bus.if_id_flush, bus.id_ex_wr_en,
              bus.id_ex_flush, bus.ex_mem_wr_en, bus.ctrl_state};
   endfunction

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%b expected=%b", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] a1, input logic e1, input logic [4:0] a2,
                        input logic e2, input logic ld, input logic [4:0] wa,
                        input logic br, input logic busy);
      bus.id_rd_addr1     = a1;
      bus.id_rd_en1       = e1;
      bus.id_rd_addr2     = a2;
      bus.id_rd_en2       = e2;
      bus.ex_mem_rd_en    = ld;
      bus.ex_wr_addr      = wa;
      bus.ex_branch_taken = br;
      bus.dmem_busy       = busy;
   endtask

   task automatic idle();
      drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic model_reset();
      stall_left = 0; flush_left = 0; waiting = 1'b0;
      m_stall_n = 0; m_flush_n = 0; m_wait_n = 0;
   endtask

   // Expected outputs for the current inputs, then advance across one edge
   task automatic model_step(output logic [7:0] exp);
      logic [5:0] o;
      logic [1:0] st;
      bit lu;
      lu = bus.ex_mem_rd_en && (bus.ex_wr_addr != 5'd0) &&
           ((bus.id_rd_en1 && bus.id_rd_addr1 == bus.ex_wr_addr) ||
            (bus.id_rd_en2 && bus.id_rd_addr2 == bus.ex_wr_addr));
      st = waiting ? 2'd3 : (flush_left > 0) ? 2'd2 : (stall_left > 0) ? 2'd1 : 2'd0;
      if (waiting) begin
         if (bus.dmem_busy) o = O_FRZ;
         else begin o = O_RUN; waiting = 1'b0; end
      end else if (bus.dmem_busy) begin
         o = O_FRZ; waiting = 1'b1;
      end else if (bus.ex_branch_taken) begin
         o = O_BR; flush_left = FL - 1; stall_left = 0;
      end else if (flush_left > 0) begin
         o = O_FLUSH; flush_left--;
      end else if (stall_left > 0) begin
         o = O_STALL; stall_left--;
      end else if (lu) begin
         o = O_STALL; stall_left = LU - 1;
      end else begin
         o = O_RUN;
      end
      if (o == O_STALL) m_stall_n++;
      if (o[3]) m_flush_n++;
      if (st == 2'd3) m_wait_n++;
      exp = {o, st};
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      repeat (2) @(negedge clk);
      check("reset_outputs", 16'(get_out()), 16'h0000);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [7:0] exp;
      logic [7:0] seq_exp[9];
      checks = 0;
      failures = 0;
      model_reset();

      tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, O_RUN,   2'd0);
      tbl[1]  = mk(0, 0, 5, 1, 1, 5, 0, 0, O_STALL, 2'd0);
      tbl[2]  = mk(0, 0, 5, 1, 1, 5, 0, 0, O_STALL, 2'd1);
      tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, O_RUN,   2'd0);
      tbl[4]  = mk(0, 0, 0, 1, 1, 0, 0, 0, O_RUN,   2'd0);
      tbl[5]  = mk(7, 1, 0, 0, 1, 7, 1, 0, O_BR,    2'd0);
      tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, O_FLUSH, 2'd2);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, O_FLUSH, 2'd2);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, O_RUN,   2'd0);
      tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 1, O_FRZ,   2'd0);
      tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, O_FRZ,   2'd3);
      tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, O_RUN,   2'd3);
      tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, O_RUN,   2'd0);
      tbl[13] = mk(3, 1, 0, 0, 1, 3, 0, 0, O_STALL, 2'd0);
      tbl[14] = mk(3, 1, 0, 0, 1, 3, 1, 0, O_BR,    2'd1);
      tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, O_FLUSH, 2'd2);
      tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, O_FRZ,   2'd2);
      tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, O_RUN,   2'd3);
      tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, O_FLUSH, 2'd2);
      tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, O_RUN,   2'd0);
      tbl[20] = mk(0, 0, 5, 0, 1, 5, 0, 0, O_RUN,   2'd0);

      // Directed vector table from reset
      do_reset();
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         drive(tbl[i].a1, tbl[i].e1, tbl[i].a2, tbl[i].e2, tbl[i].ld, tbl[i].wa,
               tbl[i].br, tbl[i].busy);
         #2;
         check($sformatf("vec%0d", i), 16'(get_out()), 16'(tbl[i].exp));
      end

      // FLUSH with two cycles left, memory busy for four cycles
      do_reset();
      seq_exp[0] = {O_BR, 2'd0};
      seq_exp[1] = {O_FRZ, 2'd2};
      seq_exp[2] = {O_FRZ, 2'd3};
      seq_exp[3] = {O_FRZ, 2'd3};
      seq_exp[4] = {O_FRZ, 2'd3};
      seq_exp[5] = {O_RUN, 2'd3};
      seq_exp[6] = {O_FLUSH, 2'd2};
      seq_exp[7] = {O_FLUSH, 2'd2};
      seq_exp[8] = {O_RUN, 2'd0};
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, (i == 0), (i >= 1 && i <= 4));
         #2;
         check($sformatf("flush_wait%0d", i), 16'(get_out()), 16'(seq_exp[i]));
      end

      // Asynchronous reset asserted in the middle of a FLUSH cycle
      do_reset();
      @(negedge clk);
      drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      @(negedge clk);
      idle();
      #2;
      check("pre_async_flush", 16'(get_out()), 16'({O_FLUSH, 2'd2}));
      #1 rst_n = 1'b0;
      #1;
      check("async_reset", 16'(get_out()), 16'h0000);

`ifdef HAZARD_PERF_COUNTERS_EN
      // Memory-wait counter saturation
      do_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      end
      @(negedge clk);
      idle();
      #2;
      check("mem_wait_saturate", 16'(bus.mem_wait_cycles_out), 16'd15);
`endif

      // Randomized stimulus against the reference model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         drive(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
         #2;
         model_step(exp);
         check($sformatf("rand%0d", i), 16'(get_out()), 16'(exp));
      end

`ifdef HAZARD_PERF_COUNTERS_EN
      @(negedge clk);
      idle();
      #2;
      check("perf_stall", 16'(bus.stall_cycles_out), 16'((m_stall_n > 15) ? 15 : m_stall_n));
      check("perf_flush", 16'(bus.flush_cycles_out), 16'((m_flush_n > 15) ? 15 : m_flush_n));
      check("perf_wait", 16'(bus.mem_wait_cycles_out), 16'((m_wait_n > 15) ? 15 : m_wait_n));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
